// File: rtl/rr_gather_if.sv
// rr_gather_if: bundle of N valid/ready source channels plus one tagged
// valid/ready output channel for the round-robin gathering multiplexer.
//   in_valid[N]     source i offers in_data[i]
//   in_data[N]      per-source word (unpacked array)
//   in_ready[N]     source i transfers this cycle (one-hot or zero)
//   out_valid       output register holds a word
//   out_data        registered word
//   out_index       source index of out_data
//   out_ready       consumer accepts out_data this cycle
// Modports: slave = the multiplexer, master = the environment driving it.
interface rr_gather_if #(
  parameter int WIDTH        = 16,
  parameter int SELECT_WIDTH = 2
);
  localparam int N = 1 << SELECT_WIDTH;

  logic [N-1:0]            in_valid;
  logic [WIDTH-1:0]        in_data [N];
  logic [N-1:0]            in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SELECT_WIDTH-1:0] out_index;
  logic                    out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index
  );
endinterface

// File: rtl/rr_gather_mux.sv
// rr_gather_mux: N-to-1 round-robin gathering multiplexer.
// Merges N = 2**SELECT_WIDTH valid/ready sources onto one registered output
// word tagged with its source index. Rotating priority starts just after the
// most recently granted source, so no continuously-valid source starves.
// Ports:
//   clk    sole clock, all state on the rising edge
//   reset  synchronous, active-high; clears the output register and points
//          the priority so index 0 is served first
//   bus    rr_gather_if.slave (in_valid/in_data/in_ready, out_valid/
//          out_data/out_index/out_ready)
module rr_gather_mux #(
  parameter int WIDTH        = 16,
  parameter int SELECT_WIDTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  rr_gather_if.slave  bus
);
  localparam int N = 1 << SELECT_WIDTH;

  logic                    out_valid_q,  out_valid_d;
  logic [WIDTH-1:0]        out_data_q,   out_data_d;
  logic [SELECT_WIDTH-1:0] out_index_q,  out_index_d;
  logic [SELECT_WIDTH-1:0] last_grant_q, last_grant_d;

  logic                    load_en;
  logic                    any_valid;
  logic                    in_xfer;
  logic [SELECT_WIDTH-1:0] grant;
  logic [N-1:0]            in_ready;

  // Arbiter: scan last_grant+1, +2, ... and take the first valid source.
  // The SELECT_WIDTH-bit sum wraps modulo N; the final offset (N) wraps back
  // to last_grant itself, so the previous winner has lowest priority.
  always_comb begin
    logic [SELECT_WIDTH-1:0] cand;
    any_valid = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int off = 1; off <= N; off++) begin
      cand = last_grant_q + SELECT_WIDTH'(off);
      if (!any_valid && bus.in_valid[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  // The register can take a new word when empty or being drained this cycle.
  assign load_en = !out_valid_q || bus.out_ready;
  assign in_xfer = load_en && any_valid && !reset;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = in_xfer && (grant == SELECT_WIDTH'(i));
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_index_d  = out_index_q;
    last_grant_d = last_grant_q;
    if (in_xfer) begin
      // Covers the simultaneous drain-and-reload case: no bubble.
      out_valid_d  = 1'b1;
      out_data_d   = bus.in_data[grant];
      out_index_d  = grant;
      last_grant_d = grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      last_grant_q <= SELECT_WIDTH'(N - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;

endmodule
